// File: rtl/mux_sched_pkg.sv
// Shared types, widths and helpers for the time-shared 8:1 mux scheduler.
package mux_sched_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Captured mux bit together with the channel it was read from
  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic             data;
  } sample_t;

  function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
    return NUM_CH'(1) << sel;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping 7->0.
// With MUX_SCHED_FIXED_PRIO_EN defined, lowest index wins and ptr is ignored.
module mux_rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

`ifdef MUX_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    pick = '0;
    any  = |req;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) pick = SEL_W'(i);
    end
  end
`else
  logic [SEL_W-1:0] idx;

  // Scan offsets high to low so the smallest offset from ptr wins
  always_comb begin
    pick = '0;
    any  = |req;
    idx  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = SEL_W'(ptr + SEL_W'(k));
      if (req[idx]) pick = idx;
    end
  end
`endif

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin time-sharing of an 8:1 bit mux: grant, hold, sample, turnaround.
// Optional MUX_SCHED_FIXED_PRIO_EN replaces round-robin with lowest-index priority.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              mux_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_valid,
  output logic              sample_out,
  output logic              sample_valid,
  output logic [SEL_W-1:0]  sample_ch
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic [NUM_CH-1:0]  gnt_d;
  logic               gnt_valid_d;
  logic               sample_valid_d;
  sample_t            sample_q, sample_d;
  logic [SEL_W-1:0]   pick;
  logic               any;
  logic [SEL_W-1:0]   ptr_in;

`ifdef MUX_SCHED_FIXED_PRIO_EN
  assign ptr_in = '0;
`else
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  assign ptr_in = ptr_q;
`endif

  mux_rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_in),
    .pick (pick),
    .any  (any)
  );

  assign sample_out = sample_q.data;
  assign sample_ch  = sample_q.ch;

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel;
    gnt_d          = gnt;
    gnt_valid_d    = gnt_valid;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
`ifndef MUX_SCHED_FIXED_PRIO_EN
    ptr_d          = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          sel_d       = pick;
          gnt_d       = onehot8(pick);
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel] || cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          // Window ends either way; only a completed window is sampled
          state_d     = GAP;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
`ifndef MUX_SCHED_FIXED_PRIO_EN
          ptr_d       = SEL_W'(sel + SEL_W'(1));
`endif
          if (req[sel]) begin
            sample_d.data  = mux_in;
            sample_d.ch    = sel;
            sample_valid_d = 1'b1;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel          <= '0;
      gnt          <= '0;
      gnt_valid    <= 1'b0;
      sample_q     <= '0;
      sample_valid <= 1'b0;
`ifndef MUX_SCHED_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel          <= sel_d;
      gnt          <= gnt_d;
      gnt_valid    <= gnt_valid_d;
      sample_q     <= sample_d;
      sample_valid <= sample_valid_d;
`ifndef MUX_SCHED_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

endmodule
